timer_ctrl_master: RTL and testbench

//  Avalon-MM master that drives the 16-bit-data interval timer slave (regs: 0 status, 1 control,
//  2/3 period L/H, 4/5 snap L/H). Programs period and start, services irq by clearing status,
//  and counts ticks. Sits between a simple local request port and the timer's s1 port, so

---
 rtl/timer_ctrl_master.sv | 249 ++++++++++++++++++++++++
 tb/tb_timer_ctrl_master.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl_master.sv
// Avalon-MM master that programs the interval timer, services its irq and counts ticks.
// Define TIMER_CTRL_SNAP_EN to add the snapshot read-back path (snap_req/snap_value/snap_valid).
module timer_ctrl_master #(
    parameter int unsigned TICK_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cfg_start,
    input  logic [31:0]       cfg_period,
    input  logic              cfg_cont,
    input  logic              stop_req,
`ifdef TIMER_CTRL_SNAP_EN
    input  logic              snap_req,
    output logic [31:0]       snap_value,
    output logic              snap_valid,
`endif
    output logic              busy,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count,
    output logic              done,
    output logic [2:0]        m_address,
    output logic              m_chipselect,
    output logic              m_write_n,
    output logic [15:0]       m_writedata,
    input  logic [15:0]       m_readdata,
    input  logic              timer_irq
);

    localparam logic [2:0] AddrStatus  = 3'd0;
    localparam logic [2:0] AddrControl = 3'd1;
    localparam logic [2:0] AddrPeriodL = 3'd2;
    localparam logic [2:0] AddrPeriodH = 3'd3;
`ifdef TIMER_CTRL_SNAP_EN
    localparam logic [2:0] AddrSnapL   = 3'd4;
    localparam logic [2:0] AddrSnapH   = 3'd5;
`endif

    typedef enum logic [3:0] {
        StIdle,
        StWrPl,
        StWrPh,
        StWrCtrl,
        StRun,
        StClrSts,
        StWrStop
`ifdef TIMER_CTRL_SNAP_EN
        ,
        StSnapWr,
        StRdL,
        StCapL,
        StCapH
`endif
    } state_e;

    state_e              state_q, state_d;
    logic [31:0]         period_q, period_d;
    logic                cont_q, cont_d;
    logic [TICK_W-1:0]   tick_count_q, tick_count_d;
    logic                tick_q, tick_d;
    logic                done_q, done_d;
    logic [2:0]          m_address_q, m_address_d;
    logic                m_chipselect_q, m_chipselect_d;
    logic                m_write_n_q, m_write_n_d;
    logic [15:0]         m_writedata_q, m_writedata_d;
`ifdef TIMER_CTRL_SNAP_EN
    logic [15:0]         snap_lo_q, snap_lo_d;
    logic [31:0]         snap_value_q, snap_value_d;
    logic                snap_valid_q, snap_valid_d;
`else
    logic                unused_readdata;
    assign unused_readdata = ^m_readdata;
`endif

    // Next-state, configuration latch, tick accounting and pulse generation.
    always_comb begin
        state_d      = state_q;
        period_d     = period_q;
        cont_d       = cont_q;
        tick_count_d = tick_count_q;
        tick_d       = 1'b0;
        done_d       = 1'b0;
`ifdef TIMER_CTRL_SNAP_EN
        snap_lo_d    = snap_lo_q;
        snap_value_d = snap_value_q;
        snap_valid_d = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (cfg_start) begin
                    state_d      = StWrPl;
                    period_d     = cfg_period;
                    cont_d       = cfg_cont;
                    tick_count_d = '0;
                end
            end
            StWrPl:   state_d = StWrPh;
            StWrPh:   state_d = StWrCtrl;
            StWrCtrl: state_d = StRun;
            StRun: begin
                // irq outranks everything so a pending timeout is never lost.
                if (timer_irq) begin
                    state_d      = StClrSts;
                    tick_d       = 1'b1;
                    tick_count_d = tick_count_q + TICK_W'(1);
                end
`ifdef TIMER_CTRL_SNAP_EN
                else if (snap_req) begin
                    state_d = StSnapWr;
                end
`endif
                else if (stop_req) begin
                    state_d = StWrStop;
                end
            end
            StClrSts: begin
                if (cont_q) begin
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            StWrStop: begin
                state_d = StIdle;
                done_d  = 1'b1;
            end
`ifdef TIMER_CTRL_SNAP_EN
            StSnapWr: state_d = StRdL;
            StRdL:    state_d = StCapL;
            StCapL: begin
                state_d   = StCapH;
                snap_lo_d = m_readdata;
            end
            StCapH: begin
                state_d      = StRun;
                snap_value_d = {m_readdata, snap_lo_q};
                snap_valid_d = 1'b1;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // Bus outputs are decoded from the next state so the registered bus matches state_q.
    always_comb begin
        m_chipselect_d = 1'b0;
        m_write_n_d    = 1'b1;
        m_address_d    = AddrStatus;
        m_writedata_d  = 16'h0000;
        case (state_d)
            StWrPl: begin
                m_chipselect_d = 1'b1;
                m_write_n_d    = 1'b0;
                m_address_d    = AddrPeriodL;
                m_writedata_d  = period_d[15:0];
            end
            StWrPh: begin
                m_chipselect_d = 1'b1;
                m_write_n_d    = 1'b0;
                m_address_d    = AddrPeriodH;
                m_writedata_d  = period_d[31:16];
            end
            StWrCtrl: begin
                m_chipselect_d = 1'b1;
                m_write_n_d    = 1'b0;
                m_address_d    = AddrControl;
                // {stop, start, cont, ito}
                m_writedata_d  = {12'b0, 1'b0, 1'b1, cont_d, 1'b1};
            end
            StClrSts: begin
                m_chipselect_d = 1'b1;
                m_write_n_d    = 1'b0;
                m_address_d    = AddrStatus;
            end
            StWrStop: begin
                m_chipselect_d = 1'b1;
                m_write_n_d    = 1'b0;
                m_address_d    = AddrControl;
                m_writedata_d  = 16'h0008;
            end
`ifdef TIMER_CTRL_SNAP_EN
            StSnapWr: begin
                m_chipselect_d = 1'b1;
                m_write_n_d    = 1'b0;
                m_address_d    = AddrSnapL;
            end
            StRdL: begin
                m_chipselect_d = 1'b1;
                m_address_d    = AddrSnapL;
            end
            StCapL: begin
                m_chipselect_d = 1'b1;
                m_address_d    = AddrSnapH;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            period_q       <= '0;
            cont_q         <= 1'b0;
            tick_count_q   <= '0;
            tick_q         <= 1'b0;
            done_q         <= 1'b0;
            m_address_q    <= '0;
            m_chipselect_q <= 1'b0;
            m_write_n_q    <= 1'b1;
            m_writedata_q  <= '0;
`ifdef TIMER_CTRL_SNAP_EN
            snap_lo_q      <= '0;
            snap_value_q   <= '0;
            snap_valid_q   <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            period_q       <= period_d;
            cont_q         <= cont_d;
            tick_count_q   <= tick_count_d;
            tick_q         <= tick_d;
            done_q         <= done_d;
            m_address_q    <= m_address_d;
            m_chipselect_q <= m_chipselect_d;
            m_write_n_q    <= m_write_n_d;
            m_writedata_q  <= m_writedata_d;
`ifdef TIMER_CTRL_SNAP_EN
            snap_lo_q      <= snap_lo_d;
            snap_value_q   <= snap_value_d;
            snap_valid_q   <= snap_valid_d;
`endif
        end
    end

    assign busy         = (state_q != StIdle);
    assign tick         = tick_q;
    assign tick_count   = tick_count_q;
    assign done         = done_q;
    assign m_address    = m_address_q;
    assign m_chipselect = m_chipselect_q;
    assign m_write_n    = m_write_n_q;
    assign m_writedata  = m_writedata_q;
`ifdef TIMER_CTRL_SNAP_EN
    assign snap_value   = snap_value_q;
    assign snap_valid   = snap_valid_q;
`endif

endmodule

// File: tb/tb_timer_ctrl_master.sv
// Randomized bench for timer_ctrl_master: expected bus cycles are queued by the stimulus and
// popped by a negedge monitor; a small model tracks ticks, done pulses and busy.
module tb_timer_ctrl_master;

    localparam int unsigned TW     = 4;
    localparam int unsigned CntMod = 1 << TW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cfg_start;
    logic [31:0]   cfg_period;
    logic          cfg_cont;
    logic          stop_req;
    logic          busy;
    logic          tick;
    logic [TW-1:0] tick_count;
    logic          done;
    logic [2:0]    m_address;
    logic          m_chipselect;
    logic          m_write_n;
    logic [15:0]   m_writedata;
    logic [15:0]   m_readdata;
    logic          timer_irq;
`ifdef TIMER_CTRL_SNAP_EN
    logic          snap_req;
    logic [31:0]   snap_value;
    logic          snap_valid;
`endif

    always #5 clk = ~clk;

    timer_ctrl_master #(.TICK_W(TW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cfg_start    (cfg_start),
        .cfg_period   (cfg_period),
        .cfg_cont     (cfg_cont),
        .stop_req     (stop_req),
`ifdef TIMER_CTRL_SNAP_EN
        .snap_req     (snap_req),
        .snap_value   (snap_value),
        .snap_valid   (snap_valid),
`endif
        .busy         (busy),
        .tick         (tick),
        .tick_count   (tick_count),
        .done         (done),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write_n    (m_write_n),
        .m_writedata  (m_writedata),
        .m_readdata   (m_readdata),
        .timer_irq    (timer_irq)
    );

    typedef struct {
        logic [2:0]  addr;
        logic        wr;
        logic [15:0] data;
        int          cyc;
    } bus_op_t;

    bus_op_t exp_q[$];
    int      checks = 0;
    int      errors = 0;
    int      cyc = 0;
    int      n_tick = 0;
    int      n_done = 0;

    // Reference model state
    bit      m_cont;
    bit      m_busy;
    int      m_count;
    int      exp_ticks;
    int      exp_done;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_op(input logic [2:0] a, input logic w, input logic [15:0] d, input int c);
        bus_op_t e;
        e.addr = a;
        e.wr   = w;
        e.data = d;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic monitor();
        bus_op_t e;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (tick) n_tick++;
                if (done) n_done++;
                if (m_chipselect) begin
                    if (exp_q.size() == 0) begin
                        check("bus_unexpected", {m_address, ~m_write_n, m_writedata}, 20'h0);
                    end else begin
                        e = exp_q.pop_front();
                        check("bus_op",
                              {m_address, ~m_write_n, m_write_n ? 16'h0 : m_writedata, cyc},
                              {e.addr, e.wr, e.wr ? e.data : 16'h0, e.cyc});
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_tick_count"}, tick_count, m_count);
        check({tag, "_busy"}, busy, m_busy);
        check({tag, "_ticks"}, n_tick, exp_ticks);
        check({tag, "_dones"}, n_done, exp_done);
    endtask

    task automatic start_cfg(input logic [31:0] p, input bit c);
        check("start_idle", busy, 1'b0);
        cfg_start  = 1'b1;
        cfg_period = p;
        cfg_cont   = c;
        push_op(3'd2, 1'b1, p[15:0], cyc + 1);
        push_op(3'd3, 1'b1, p[31:16], cyc + 2);
        push_op(3'd1, 1'b1, 16'h0005 | (c ? 16'h0002 : 16'h0000), cyc + 3);
        m_cont  = c;
        m_count = 0;
        m_busy  = 1'b1;
        step();
        cfg_start  = 1'b0;
        cfg_period = $urandom;
        cfg_cont   = 1'($urandom);
        check("cfg_busy", busy, 1'b1);
        step();
        step();
        step();
    endtask

    // Timer asserts irq in RUN; it drops once the status write has landed.
    task automatic fire_irq(input bit with_stop);
        timer_irq = 1'b1;
        stop_req  = with_stop;
        push_op(3'd0, 1'b1, 16'h0000, cyc + 1);
        m_count = (m_count + 1) % CntMod;
        exp_ticks++;
        if (m_cont && with_stop) push_op(3'd1, 1'b1, 16'h0008, cyc + 3);
        if (!m_cont || with_stop) begin
            exp_done++;
            m_busy = 1'b0;
        end
        step();
        step();
        timer_irq = 1'b0;
        step();
        stop_req = 1'b0;
        step();
        step();
    endtask

    task automatic stop_only();
        stop_req = 1'b1;
        push_op(3'd1, 1'b1, 16'h0008, cyc + 1);
        exp_done++;
        m_busy = 1'b0;
        step();
        stop_req = 1'b0;
        step();
        step();
    endtask

    task automatic busy_cfg_ignored();
        cfg_start  = 1'b1;
        cfg_period = $urandom;
        cfg_cont   = 1'($urandom);
        step();
        cfg_start = 1'b0;
        step();
        check("cfg_ignored_count", tick_count, m_count);
    endtask

`ifdef TIMER_CTRL_SNAP_EN
    task automatic do_snap(input logic [31:0] val);
        snap_req = 1'b1;
        push_op(3'd4, 1'b1, 16'h0000, cyc + 1);
        push_op(3'd4, 1'b0, 16'h0000, cyc + 2);
        push_op(3'd5, 1'b0, 16'h0000, cyc + 3);
        step();
        snap_req = 1'b0;
        step();
        step();
        m_readdata = val[15:0];
        step();
        m_readdata = val[31:16];
        step();
        m_readdata = 16'hDEAD;
        check("snap_valid_pulse", snap_valid, 1'b1);
        check("snap_value", snap_value, val);
        step();
        check("snap_valid_low", snap_valid, 1'b0);
    endtask
`endif

    initial begin
        bit c;
        bit stop_last;
        int n;
        logic [31:0] p;

        reset_n    = 1'b0;
        cfg_start  = 1'b0;
        cfg_period = '0;
        cfg_cont   = 1'b0;
        stop_req   = 1'b0;
        timer_irq  = 1'b0;
        m_readdata = 16'hDEAD;
`ifdef TIMER_CTRL_SNAP_EN
        snap_req   = 1'b0;
`endif
        m_cont = 1'b0;
        m_busy = 1'b0;
        m_count = 0;
        exp_ticks = 0;
        exp_done = 0;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        check("rst_chipselect", m_chipselect, 1'b0);
        check("rst_write_n", m_write_n, 1'b1);
        check("rst_address", m_address, 3'd0);
        check("rst_writedata", m_writedata, 16'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_tick", tick, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_tick_count", tick_count, 0);
`ifdef TIMER_CTRL_SNAP_EN
        check("rst_snap_valid", snap_valid, 1'b0);
        check("rst_snap_value", snap_value, 32'h0);
`endif
        reset_n = 1'b1;
        step();

        start_cfg(32'h0001_86A0, 1'b1);
        check_state("cfg_cont");
        repeat (3) begin
            fire_irq(1'b0);
            step();
        end
        check_state("three_irqs");
        busy_cfg_ignored();
`ifdef TIMER_CTRL_SNAP_EN
        do_snap(32'h0001_2345);
`endif
        stop_only();
        check_state("stop");

        start_cfg($urandom, 1'b0);
        fire_irq(1'b0);
        check_state("one_shot");

        start_cfg($urandom, 1'b1);
        fire_irq(1'b0);
        fire_irq(1'b1);
        check_state("irq_and_stop");

        // Long continuous run so tick_count wraps past 2^TW-1.
        start_cfg(32'h0, 1'b1);
        repeat (CntMod + 2) fire_irq(1'b0);
        check_state("wrap");
        stop_only();

        for (int s = 0; s < 30; s++) begin
            p = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            c = 1'($urandom);
            start_cfg(p, c);
            if (!c) begin
                repeat ($urandom_range(0, 2)) step();
                fire_irq(1'($urandom));
            end else begin
                n = $urandom_range(1, 4);
                stop_last = 1'($urandom);
                for (int i = 0; i < n; i++) begin
                    repeat ($urandom_range(0, 2)) step();
                    if ($urandom_range(0, 3) == 0) busy_cfg_ignored();
`ifdef TIMER_CTRL_SNAP_EN
                    if ($urandom_range(0, 3) == 0) do_snap($urandom);
`endif
                    fire_irq(stop_last && (i == n - 1));
                end
                if (!stop_last) stop_only();
            end
            check_state("rnd");
        end

        // Reset while WR_PH is on the bus: only the WR_PL cycle is seen.
        check("rst_mid_idle", busy, 1'b0);
        cfg_start  = 1'b1;
        cfg_period = 32'hCAFE_1234;
        cfg_cont   = 1'b1;
        push_op(3'd2, 1'b1, 16'h1234, cyc + 1);
        step();
        cfg_start = 1'b0;
        step();
        reset_n = 1'b0;
        #1;
        check("rst_mid_chipselect", m_chipselect, 1'b0);
        check("rst_mid_write_n", m_write_n, 1'b1);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_tick_count", tick_count, 0);
        m_busy  = 1'b0;
        m_count = 0;
        step();
        step();
        reset_n = 1'b1;
        step();

        start_cfg(32'h0000_0010, 1'b0);
        fire_irq(1'b0);
        check_state("after_reset");

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        check("drain_queue", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
